// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a combinational block through every input vector,
// compares each response with an expected truth table and holds the verdict.
module truth_table_sweeper #(
   parameter int N_IN         = 4,
   parameter int SETTLE       = 1,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2**N_IN-1:0]   expected,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        fail_count,
   output logic [N_IN-1:0]      first_fail_idx,
   output logic [2**N_IN-1:0]   captured
);
   localparam int NV = 2**N_IN;
   typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;
   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d, ff_q, ff_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [NV-1:0]     exp_q, exp_d, cap_q, cap_d;
   logic [N_IN:0]     fc_q, fc_d;
   logic              pass_q, pass_d, mis;
   state_t            vec_entry;
   assign vec_entry = (SETTLE == 0) ? SAMPLE : HOLD;
   assign mis = dut_out != exp_q[idx_q];
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      cap_d   = cap_q;
      fc_d    = fc_q;
      ff_d    = ff_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = vec_entry;
            exp_d   = expected;
            cap_d   = '0;
            fc_d    = '0;
            ff_d    = '0;
            pass_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
         end
         HOLD: if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
         end else if (cnt_q == 8'(SETTLE - 1)) begin
            state_d = SAMPLE;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + 8'd1;
         end
         SAMPLE: if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
         end else begin
            cap_d[idx_q] = dut_out;
            fc_d = fc_q + {{N_IN{1'b0}}, mis};
            ff_d = (mis && fc_q == '0) ? idx_q : ff_q;
            // Verdict is registered on the way into FINISH so it is valid alongside done.
            if ((&idx_q) || (STOP_ON_FAIL != 0 && mis)) begin
               state_d = FINISH;
               pass_d  = (fc_q == '0) && !mis;
            end else begin
               state_d = vec_entry;
               idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         cap_q   <= '0;
         fc_q    <= '0;
         ff_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         cap_q   <= cap_d;
         fc_q    <= fc_d;
         ff_q    <= ff_d;
         pass_q  <= pass_d;
      end
   end
   assign busy           = state_q == HOLD || state_q == SAMPLE;
   assign done           = state_q == FINISH;
   assign dut_in         = busy ? idx_q : '0;
   assign pass           = pass_q;
   assign fail_count     = fc_q;
   assign first_fail_idx = ff_q;
   assign captured       = cap_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: three sweeper configurations (settle 1, stop-on-fail,
// settle 0) driven side by side against a truth-table model with injected faults.
module tb_truth_table_sweeper;
   logic        clk = 1'b0;
   logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [15:0] tbl = '0, inj = '0;
   logic [3:0]  din [3];
   logic [2:0]  dout, busy, done, pass;
   logic [4:0]  fc [3];
   logic [3:0]  ff [3];
   logic [15:0] cap [3];
   int          passed = 0, total = 0;
   int          dcyc [3];
   logic        spass [3];
   logic [4:0]  sfc [3];
   logic [3:0]  sff [3];
   logic [15:0] scap [3];
   logic [3:0]  trace [41];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign dout[g] = tbl[din[g]] ^ inj[din[g]];
      truth_table_sweeper #(.N_IN(4), .SETTLE(g == 2 ? 0 : 1), .STOP_ON_FAIL(g == 1 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(tbl),
         .dut_in(din[g]), .dut_out(dout[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
         .fail_count(fc[g]), .first_fail_idx(ff[g]), .captured(cap[g]));
   end

   // Reference: captured is the DUT table, every injected bit is a mismatch.
   task automatic model(input logic [15:0] t, input logic [15:0] m, input int s, input bit stp,
                        output int dc, output logic ep, output logic [4:0] efc,
                        output logic [3:0] eff, output logic [15:0] ecap);
      int last;
      last = 15; efc = '0; eff = '0; ecap = '0;
      for (int v = 0; v < 16; v++) begin
         ecap[v] = t[v] ^ m[v];
         if (m[v]) begin
            if (efc == 0) eff = 4'(v);
            efc++;
            if (stp) begin
               last = v;
               break;
            end
         end
      end
      dc = (last + 1) * (s + 1) + 1;
      ep = (efc == 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic run_sweep();
      for (int k = 0; k < 3; k++) dcyc[k] = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         trace[c] = din[0];
         for (int k = 0; k < 3; k++)
            if (done[k] && dcyc[k] == 0) begin
               dcyc[k] = c; spass[k] = pass[k]; sfc[k] = fc[k]; sff[k] = ff[k]; scap[k] = cap[k];
            end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b1;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({din[k], busy[k], done[k], pass[k], fc[k], ff[k], cap[k]} !== '0)
            $display("FAIL reset[%0d]: got din=%h busy=%b done=%b pass=%b fc=%h ff=%h cap=%h, want all 0",
                     k, din[k], busy[k], done[k], pass[k], fc[k], ff[k], cap[k]);
         else passed++;
      end
      start = 1'b0; abort = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_match();
      do_reset();
      tbl = 16'hEF69; inj = '0;
      run_sweep();
      total++; if (dcyc[0] !== 33) $display("FAIL match_done_cycle: got %0d want 33", dcyc[0]); else passed++;
      total++; if (dcyc[2] !== 17) $display("FAIL match_done_cycle_s0: got %0d want 17", dcyc[2]); else passed++;
      total++; if (spass[0] !== 1'b1) $display("FAIL match_pass: got %b want 1", spass[0]); else passed++;
      total++; if (sfc[0] !== 5'd0) $display("FAIL match_fail_count: got %0d want 0", sfc[0]); else passed++;
      total++; if (sff[0] !== 4'd0) $display("FAIL match_first_fail: got %0d want 0", sff[0]); else passed++;
      total++; if (scap[0] !== 16'hEF69) $display("FAIL match_captured: got %h want ef69", scap[0]); else passed++;
      for (int c = 1; c <= 33; c++) begin
         total++;
         if (trace[c] !== ((c <= 32) ? 4'((c - 1) / 2) : 4'd0))
            $display("FAIL match_dut_in cycle %0d: got %0d want %0d", c, trace[c], (c <= 32) ? (c - 1) / 2 : 0);
         else passed++;
      end
   endtask

   task automatic test_inject();
      do_reset();
      tbl = 16'hEF69; inj = 16'h1020;
      run_sweep();
      total++; if (dcyc[0] !== 33) $display("FAIL inject_done_cycle: got %0d want 33", dcyc[0]); else passed++;
      total++; if (spass[0] !== 1'b0) $display("FAIL inject_pass: got %b want 0", spass[0]); else passed++;
      total++; if (sfc[0] !== 5'd2) $display("FAIL inject_fail_count: got %0d want 2", sfc[0]); else passed++;
      total++; if (sff[0] !== 4'd5) $display("FAIL inject_first_fail: got %0d want 5", sff[0]); else passed++;
      total++; if (scap[0] !== 16'hFF49) $display("FAIL inject_captured: got %h want ff49", scap[0]); else passed++;
   endtask

   task automatic test_early_stop();
      do_reset();
      tbl = 16'hEF69; inj = 16'h0020;
      run_sweep();
      total++; if (dcyc[1] !== 13) $display("FAIL stop_done_cycle: got %0d want 13", dcyc[1]); else passed++;
      total++; if (sfc[1] !== 5'd1) $display("FAIL stop_fail_count: got %0d want 1", sfc[1]); else passed++;
      total++; if (sff[1] !== 4'd5) $display("FAIL stop_first_fail: got %0d want 5", sff[1]); else passed++;
      total++; if (spass[1] !== 1'b0) $display("FAIL stop_pass: got %b want 0", spass[1]); else passed++;
      // Vectors 6..15 are never sampled, so only bits 0..5 can be set.
      total++; if (scap[1] !== 16'h0009) $display("FAIL stop_captured: got %h want 0009", scap[1]); else passed++;
   endtask

   task automatic test_random();
      int dc; logic ep; logic [4:0] efc; logic [3:0] eff; logic [15:0] ecap;
      do_reset();
      for (int it = 0; it < 8; it++) begin
         tbl = 16'($urandom);
         inj = (it == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
         run_sweep();
         for (int k = 0; k < 3; k++) begin
            model(tbl, inj, (k == 2) ? 0 : 1, k == 1, dc, ep, efc, eff, ecap);
            total++; if (dcyc[k] !== dc) $display("FAIL rand%0d[%0d]_done_cycle: got %0d want %0d", it, k, dcyc[k], dc); else passed++;
            total++; if (spass[k] !== ep) $display("FAIL rand%0d[%0d]_pass: got %b want %b", it, k, spass[k], ep); else passed++;
            total++; if (sfc[k] !== efc) $display("FAIL rand%0d[%0d]_fail_count: got %0d want %0d", it, k, sfc[k], efc); else passed++;
            total++; if (sff[k] !== eff) $display("FAIL rand%0d[%0d]_first_fail: got %0d want %0d", it, k, sff[k], eff); else passed++;
            total++; if (scap[k] !== ecap) $display("FAIL rand%0d[%0d]_captured: got %h want %h", it, k, scap[k], ecap); else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int c, dc, got; logic ep; logic [4:0] efc; logic [3:0] eff; logic [15:0] ecap;
      logic gp; logic [4:0] gfc; logic [3:0] gff; logic [15:0] gcap;
      do_reset();
      tbl = 16'($urandom); inj = '0;
      start = 1'b1; tick(); start = 1'b0;
      c = 1;
      while (!done[0] && c < 40) begin tick(); c++; end
      total++; if (!done[0] || c != 33) $display("FAIL b2b_first_done: got cycle %0d done=%b want cycle 33", c, done[0]); else passed++;
      start = 1'b1;
      tick();
      total++; if (busy[0] !== 1'b0) $display("FAIL b2b_start_in_finish: got busy=%b want 0", busy[0]); else passed++;
      tbl = 16'($urandom); inj = 16'($urandom & $urandom & $urandom);
      tick();
      start = 1'b0;
      total++; if (busy[0] !== 1'b1) $display("FAIL b2b_restart: got busy=%b want 1", busy[0]); else passed++;
      got = 0; gp = 1'bx; gfc = 'x; gff = 'x; gcap = 'x;
      for (int n = 1; n <= 40; n++) begin
         if (done[0] && got == 0) begin got = n; gp = pass[0]; gfc = fc[0]; gff = ff[0]; gcap = cap[0]; end
         tick();
      end
      model(tbl, inj, 1, 1'b0, dc, ep, efc, eff, ecap);
      total++; if (got !== dc) $display("FAIL b2b_second_done: got %0d want %0d", got, dc); else passed++;
      total++; if ({gp, gfc, gff, gcap} !== {ep, efc, eff, ecap})
         $display("FAIL b2b_results: got pass=%b fc=%0d ff=%0d cap=%h want pass=%b fc=%0d ff=%0d cap=%h",
                  gp, gfc, gff, gcap, ep, efc, eff, ecap);
      else passed++;
   endtask

   task automatic test_start_held();
      do_reset();
      tbl = 16'($urandom); inj = '0;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 60; c++) begin
         total++;
         if (done[2] !== (c % 18 == 17)) $display("FAIL held_done cycle %0d: got %b want %b", c, done[2], c % 18 == 17); else passed++;
         total++;
         if (busy[2] !== !(c % 18 == 17 || c % 18 == 0))
            $display("FAIL held_busy cycle %0d: got %b want %b", c, busy[2], !(c % 18 == 17 || c % 18 == 0));
         else passed++;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_abort();
      int seen;
      do_reset();
      tbl = 16'($urandom); inj = '0;
      run_sweep();
      total++; if (spass[0] !== 1'b1) $display("FAIL abort_prior_pass: got %b want 1", spass[0]); else passed++;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (busy[0] !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy[0]); else passed++;
      total++; if (din[0] !== 4'd0) $display("FAIL abort_dut_in: got %0d want 0", din[0]); else passed++;
      total++; if (pass[0] !== 1'b0) $display("FAIL abort_pass: got %b want 0", pass[0]); else passed++;
      seen = 0;
      for (int c = 11; c <= 50; c++) begin
         if (done[0] || busy[0]) seen++;
         tick();
      end
      total++; if (seen != 0) $display("FAIL abort_no_done: got %0d active cycles want 0", seen); else passed++;
   endtask

   task automatic test_reset_mid();
      int dc; logic ep; logic [4:0] efc; logic [3:0] eff; logic [15:0] ecap;
      do_reset();
      tbl = 16'($urandom); inj = 16'($urandom & $urandom);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      rst = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({din[k], busy[k], done[k], pass[k], fc[k], ff[k], cap[k]} !== '0)
            $display("FAIL midreset[%0d]: got din=%h busy=%b done=%b pass=%b fc=%h ff=%h cap=%h, want all 0",
                     k, din[k], busy[k], done[k], pass[k], fc[k], ff[k], cap[k]);
         else passed++;
      end
      rst = 1'b0;
      tick();
      tbl = 16'($urandom); inj = 16'($urandom & $urandom & $urandom);
      run_sweep();
      model(tbl, inj, 1, 1'b0, dc, ep, efc, eff, ecap);
      total++; if (dcyc[0] !== 33) $display("FAIL midreset_done_cycle: got %0d want 33", dcyc[0]); else passed++;
      total++; if ({spass[0], sfc[0], sff[0], scap[0]} !== {ep, efc, eff, ecap})
         $display("FAIL midreset_results: got pass=%b fc=%0d ff=%0d cap=%h want pass=%b fc=%0d ff=%0d cap=%h",
                  spass[0], sfc[0], sff[0], scap[0], ep, efc, eff, ecap);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_match();
      test_inject();
      test_early_stop();
      test_random();
      test_back_to_back();
      test_start_held();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
